// File: rtl/cpu_ctrl_pkg.sv
// Shared control-word layout, Psel/state encodings and status bit indices
// for the multi-cycle LEGv8 control path.
package cpu_ctrl_pkg;

  localparam int CW_W     = 31;
  localparam int PSEL_HI  = 30;
  localparam int PSEL_LO  = 29;
  localparam int DA_HI    = 28;
  localparam int DA_LO    = 24;
  localparam int SA_HI    = 23;
  localparam int SA_LO    = 19;
  localparam int SB_HI    = 18;
  localparam int SB_LO    = 14;
  localparam int FSEL_HI  = 13;
  localparam int FSEL_LO  = 9;
  localparam int REG_W    = 8;
  localparam int RAM_W    = 7;
  localparam int EN_MEM   = 6;
  localparam int EN_ALU   = 5;
  localparam int EN_B     = 4;
  localparam int EN_PC    = 3;
  localparam int BSEL     = 2;
  localparam int PCSEL    = 1;
  localparam int SL       = 0;

  typedef enum logic [1:0] {
    PSEL_HOLD = 2'b00,
    PSEL_INC  = 2'b01,
    PSEL_ABS  = 2'b10,
    PSEL_REL  = 2'b11
  } psel_e;

  localparam logic [1:0] ST_FETCH = 2'b00;

  localparam int STAT_V = 3;
  localparam int STAT_C = 2;
  localparam int STAT_Z = 1;
  localparam int STAT_N = 0;

  function automatic psel_e get_psel(input logic [CW_W-1:0] cw);
    return psel_e'(cw[PSEL_HI:PSEL_LO]);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Decoder-facing bundle of the fetch sequencer: control inputs from the
// per-opcode decoders and the instruction/state/status feedback to them.
interface fetch_sequencer_if;
  logic [30:0] control_word;
  logic [1:0]  next_state;
  logic [63:0] k;
  logic [63:0] data_in;
  logic [3:0]  alu_status;
  logic [31:0] imem_data;
  logic [63:0] imem_addr;
  logic [31:0] instruction;
  logic [1:0]  state;
  logic [3:0]  status;
  logic [63:0] pc_link;
  logic        pc_link_en;
  logic        align_fault;
  logic [31:0] retired;

  modport master (
    output control_word, next_state, k, data_in, alu_status, imem_data,
    input  imem_addr, instruction, state, status, pc_link, pc_link_en,
           align_fault, retired
  );

  modport slave (
    input  control_word, next_state, k, data_in, alu_status, imem_data,
    output imem_addr, instruction, state, status, pc_link, pc_link_en,
           align_fault, retired
  );
endinterface

// File: rtl/fetch_sequencer_pc_next_logic.sv
// Combinational next-PC selection and misaligned-target detection.
import cpu_ctrl_pkg::*;

module pc_next_logic #(
  parameter int PC_W = 64
) (
  input  logic [PC_W-1:0] pc,
  input  psel_e           psel,
  input  logic            pcsel,
  input  logic [PC_W-1:0] k,
  input  logic [PC_W-1:0] data_in,
  output logic [PC_W-1:0] pc_next,
  output logic            misaligned
);

  logic [PC_W-1:0] off;
  logic [PC_W-1:0] pc_plus4;

  assign off      = pcsel ? k : data_in;
  assign pc_plus4 = pc + PC_W'(4);

  always_comb begin
    pc_next    = pc;
    misaligned = 1'b0;
    case (psel)
      PSEL_HOLD: pc_next = pc;
      PSEL_INC:  pc_next = pc_plus4;
      PSEL_ABS: begin
        pc_next    = {data_in[PC_W-1:2], 2'b00};
        misaligned = (data_in[1:0] != 2'b00);
      end
      PSEL_REL:  pc_next = pc_plus4 + {off[PC_W-3:0], 2'b00};
      default:   pc_next = pc;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch front end: PC, instruction register, micro-state, status flags,
// sticky alignment fault and retired-instruction counter.
import cpu_ctrl_pkg::*;

module fetch_sequencer #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          PC_W     = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  fetch_sequencer_if.slave  bus
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [1:0]      state_q, state_d;
  logic [3:0]      status_q, status_d;
  logic            fault_q, fault_d;
  logic [31:0]     retired_q, retired_d;

  logic [PC_W-1:0] pc_next;
  logic            misaligned;
  logic            unused_cw;

  assign unused_cw = ^{bus.control_word[DA_HI:EN_B], bus.control_word[BSEL]};

  pc_next_logic #(.PC_W(PC_W)) u_pc_next (
    .pc         (pc_q),
    .psel       (get_psel(bus.control_word)),
    .pcsel      (bus.control_word[PCSEL]),
    .k          (bus.k),
    .data_in    (bus.data_in),
    .pc_next    (pc_next),
    .misaligned (misaligned)
  );

  always_comb begin
    pc_d      = pc_q;
    ir_d      = ir_q;
    state_d   = state_q;
    status_d  = status_q;
    fault_d   = fault_q;
    retired_d = retired_q;
    if (!stall) begin
      pc_d    = pc_next;
      state_d = bus.next_state;
      if (state_q == ST_FETCH)
        ir_d = bus.imem_data;
      if (bus.control_word[SL])
        status_d = bus.alu_status;
      if (misaligned)
        fault_d = 1'b1;
      if (bus.next_state == ST_FETCH)
        retired_d = retired_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      state_q   <= ST_FETCH;
      status_q  <= '0;
      fault_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      state_q   <= state_d;
      status_q  <= status_d;
      fault_q   <= fault_d;
      retired_q <= retired_d;
    end
  end

  // In the fetch state the decoders see memory directly; later micro-states
  // use the latched copy so an early PC update cannot disturb them.
  assign bus.instruction = (state_q == ST_FETCH) ? bus.imem_data : ir_q;
  assign bus.imem_addr   = pc_q;
  assign bus.pc_link     = pc_q + PC_W'(4);
  assign bus.pc_link_en  = bus.control_word[EN_PC];
  assign bus.state       = state_q;
  assign bus.status      = status_q;
  assign bus.align_fault = fault_q;
  assign bus.retired     = retired_q;

endmodule
